// File: rtl/ysyx_lsu_sq.sv
// Post-commit store queue: buffers retired stores in program order and drains them one at a time
// to the data-memory write channel. It also flags loads that alias a pending store.
module ysyx_lsu_sq #(
   parameter int unsigned SQ_SIZE = 4,
   parameter int unsigned XLEN    = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            rou_valid,
   input  logic            rou_store,
   input  logic [4:0]      rou_alu,
   input  logic [XLEN-1:0] rou_sq_waddr,
   input  logic [XLEN-1:0] rou_sq_wdata,
   input  logic [XLEN-1:0] rou_pc,
   output logic            sq_ready,
   output logic            sq_empty,
   output logic            mem_wvalid,
   output logic [XLEN-1:0] mem_waddr,
   output logic [XLEN-1:0] mem_wdata,
   output logic [3:0]      mem_wstrb,
   input  logic            mem_wready,
   input  logic            mem_bvalid,
   input  logic            mem_berr,
   input  logic [XLEN-1:0] ld_raddr,
   output logic            ld_conflict,
   output logic            store_fault
);

   localparam int unsigned PW = $clog2(SQ_SIZE);
   localparam logic [PW:0] FullCnt = (PW+1)'(SQ_SIZE);

   typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
   logic [PW:0]     count_q, count_d;
   logic            fault_q, fault_d;
   logic            latch_head;
   logic            push, pop;

   logic [XLEN-1:0] ent_waddr_q [SQ_SIZE];
   logic [XLEN-1:0] ent_wdata_q [SQ_SIZE];
   logic [3:0]      ent_wstrb_q [SQ_SIZE];
   logic [XLEN-1:0] ent_pc_q    [SQ_SIZE];

   logic [XLEN-1:0] out_waddr_q, out_wdata_q;
   logic [3:0]      out_wstrb_q;

   logic [XLEN-1:0] fmt_waddr, fmt_wdata, ld_word;
   logic [3:0]      fmt_wstrb;

   assign sq_ready   = (count_q != FullCnt);
   assign sq_empty   = (count_q == '0) && (state_q == StIdle);
   assign mem_wvalid = (state_q == StReq);
   assign mem_waddr  = out_waddr_q;
   assign mem_wdata  = out_wdata_q;
   assign mem_wstrb  = out_wstrb_q;
   assign store_fault = fault_q;

   assign push = rou_valid && rou_store && sq_ready;
   assign pop  = (state_q == StResp) && mem_bvalid;

   // Replicate the narrow store across all lanes; the strobe selects the live bytes.
   always_comb begin
      fmt_waddr = {rou_sq_waddr[XLEN-1:2], 2'b00};
      case (rou_alu[1:0])
         2'b00: begin
            fmt_wstrb = 4'b0001 << rou_sq_waddr[1:0];
            fmt_wdata = {(XLEN/8){rou_sq_wdata[7:0]}};
         end
         2'b01: begin
            fmt_wstrb = 4'b0011 << {rou_sq_waddr[1], 1'b0};
            fmt_wdata = {(XLEN/16){rou_sq_wdata[15:0]}};
         end
         default: begin
            fmt_wstrb = 4'b1111;
            fmt_wdata = rou_sq_wdata;
         end
      endcase
   end

   always_comb begin
      count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
      head_d  = head_q + PW'(pop);
      tail_d  = tail_q + PW'(push);
      fault_d = fault_q | (pop & mem_berr);
   end

   always_comb begin
      state_d    = state_q;
      latch_head = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (count_q != '0) begin
               state_d    = StReq;
               latch_head = 1'b1;
            end
         end
         StReq:  if (mem_wready) state_d = StResp;
         StResp: if (mem_bvalid) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Slot i is live when its distance from head is below count; the in-flight head counts too.
   always_comb begin
      ld_word     = {ld_raddr[XLEN-1:2], 2'b00};
      ld_conflict = 1'b0;
      for (int unsigned i = 0; i < SQ_SIZE; i++) begin
         if (({1'b0, PW'(i) - head_q} < count_q) && (ent_waddr_q[i] == ld_word)) begin
            ld_conflict = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= StIdle;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         fault_q     <= 1'b0;
         out_waddr_q <= '0;
         out_wdata_q <= '0;
         out_wstrb_q <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         fault_q <= fault_d;
         if (latch_head) begin
            out_waddr_q <= ent_waddr_q[head_q];
            out_wdata_q <= ent_wdata_q[head_q];
            out_wstrb_q <= ent_wstrb_q[head_q];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         ent_waddr_q[tail_q] <= fmt_waddr;
         ent_wdata_q[tail_q] <= fmt_wdata;
         ent_wstrb_q[tail_q] <= fmt_wstrb;
         ent_pc_q[tail_q]    <= rou_pc;
      end
   end

   // The stored PC is debug state only.
   logic unused_sig;
   assign unused_sig = ^{rou_alu[4:2], ld_raddr[1:0], ent_pc_q[head_q]};

endmodule

// File: tb/tb_ysyx_lsu_sq.sv
// Bench for ysyx_lsu_sq: directed scenarios plus random traffic, all checked each cycle
// against a queue-based reference model of the store queue.
module tb_ysyx_lsu_sq;

   localparam int SQ = 4;

   logic        clock, reset;
   logic        rou_valid, rou_store;
   logic [4:0]  rou_alu;
   logic [31:0] rou_sq_waddr, rou_sq_wdata, rou_pc;
   logic        sq_ready, sq_empty, mem_wvalid;
   logic [31:0] mem_waddr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_wready, mem_bvalid, mem_berr;
   logic [31:0] ld_raddr;
   logic        ld_conflict, store_fault;

   ysyx_lsu_sq #(.SQ_SIZE(SQ), .XLEN(32)) dut (
      .clock        (clock),
      .reset        (reset),
      .rou_valid    (rou_valid),
      .rou_store    (rou_store),
      .rou_alu      (rou_alu),
      .rou_sq_waddr (rou_sq_waddr),
      .rou_sq_wdata (rou_sq_wdata),
      .rou_pc       (rou_pc),
      .sq_ready     (sq_ready),
      .sq_empty     (sq_empty),
      .mem_wvalid   (mem_wvalid),
      .mem_waddr    (mem_waddr),
      .mem_wdata    (mem_wdata),
      .mem_wstrb    (mem_wstrb),
      .mem_wready   (mem_wready),
      .mem_bvalid   (mem_bvalid),
      .mem_berr     (mem_berr),
      .ld_raddr     (ld_raddr),
      .ld_conflict  (ld_conflict),
      .store_fault  (store_fault)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
   } ent_t;

   // Reference model: pending stores in program order, drain phase, sticky fault, output regs.
   ent_t q[$];
   int   ph;       // 0 idle, 1 request outstanding, 2 awaiting response
   logic flt;
   ent_t outr;
   bit   m_acc;

   int total = 0;
   int bad   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic ent_t fmt(input logic [4:0] alu, input logic [31:0] a, input logic [31:0] d);
      ent_t e;
      e.a = a & ~32'h3;
      case (alu[1:0])
         2'b00: begin
            e.s = 4'(1 << a[1:0]);
            e.d = 32'h0101_0101 * {24'h0, d[7:0]};
         end
         2'b01: begin
            e.s = a[1] ? 4'b1100 : 4'b0011;
            e.d = 32'h0001_0001 * {16'h0, d[15:0]};
         end
         default: begin
            e.s = 4'b1111;
            e.d = d;
         end
      endcase
      return e;
   endfunction

   task automatic model_advance();
      bit push_ok, popped;
      m_acc = 0;
      if (!reset) begin
         q.delete();
         ph   = 0;
         flt  = 1'b0;
         outr = '0;
         return;
      end
      push_ok = rou_valid && rou_store && (q.size() != SQ);
      popped  = 0;
      case (ph)
         0: if (q.size() != 0) begin ph = 1; outr = q[0]; end
         1: if (mem_wready) ph = 2;
         default: if (mem_bvalid) begin
            popped = 1;
            ph = 0;
            if (mem_berr) flt = 1'b1;
         end
      endcase
      if (popped) void'(q.pop_front());
      if (push_ok) begin
         q.push_back(fmt(rou_alu, rou_sq_waddr, rou_sq_wdata));
         m_acc = 1;
      end
   endtask

   task automatic step();
      bit hit;
      @(negedge clock);
      hit = 0;
      foreach (q[i]) if (q[i].a == (ld_raddr & ~32'h3)) hit = 1;
      check_eq("sq_ready",    32'(sq_ready),    32'(q.size() != SQ));
      check_eq("sq_empty",    32'(sq_empty),    32'(q.size() == 0 && ph == 0));
      check_eq("mem_wvalid",  32'(mem_wvalid),  32'(ph == 1));
      check_eq("mem_waddr",   mem_waddr,        outr.a);
      check_eq("mem_wdata",   mem_wdata,        outr.d);
      check_eq("mem_wstrb",   32'(mem_wstrb),   32'(outr.s));
      check_eq("ld_conflict", 32'(ld_conflict), 32'(hit));
      check_eq("store_fault", 32'(store_fault), 32'(flt));
      model_advance();
      @(posedge clock);
      #1;
   endtask

   task automatic set_store(input logic [4:0] alu, input logic [31:0] a, input logic [31:0] d);
      rou_valid    = 1'b1;
      rou_store    = 1'b1;
      rou_alu      = alu;
      rou_sq_waddr = a;
      rou_sq_wdata = d;
      rou_pc       = a ^ 32'h8000_0000;
   endtask

   task automatic drain(input int n);
      rou_valid = 1'b0;
      repeat (n) step();
   endtask

   initial begin
      int tries;
      reset = 1'b0;
      rou_valid = 1'b0; rou_store = 1'b0; rou_alu = '0;
      rou_sq_waddr = '0; rou_sq_wdata = '0; rou_pc = '0;
      mem_wready = 1'b0; mem_bvalid = 1'b0; mem_berr = 1'b0; ld_raddr = '0;
      q.delete(); ph = 0; flt = 1'b0; outr = '0;
      @(posedge clock);
      #1;
      step();
      reset = 1'b1;
      step();

      // Single SW, then byte and halfword lane placement
      mem_wready = 1'b1; mem_bvalid = 1'b1;
      set_store(5'b00010, 32'h8000_0004, 32'hDEAD_BEEF);
      step();
      drain(6);
      set_store(5'b00000, 32'h0000_0103, 32'h0000_005A);
      step();
      set_store(5'b00001, 32'h0000_0102, 32'h0000_1234);
      step();
      drain(10);

      // Fill to capacity with the write channel stalled, then drain across a pointer wrap
      mem_wready = 1'b0; mem_bvalid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         set_store(5'b00010, 32'h3000 + 32'(4 * k), 32'(k));
         tries = 0;
         do begin
            if (tries == 3) begin mem_wready = 1'b1; mem_bvalid = 1'b1; end
            step();
            tries++;
         end while (!m_acc && tries < 40);
      end
      drain(30);

      // Load aliasing against a parked store
      mem_wready = 1'b0; mem_bvalid = 1'b0;
      set_store(5'b00010, 32'h0000_0200, 32'h1111_2222);
      step();
      rou_valid = 1'b0;
      ld_raddr = 32'h0000_0203;
      step(); step();
      ld_raddr = 32'h0000_0204;
      step();
      ld_raddr = 32'h0000_0200;
      mem_wready = 1'b1; mem_bvalid = 1'b1;
      drain(6);

      // Bus error is sticky and still pops; reset while a request is outstanding
      mem_berr = 1'b1;
      set_store(5'b00010, 32'h0000_0400, 32'hCAFE_F00D);
      step();
      drain(6);
      mem_berr = 1'b0;
      mem_wready = 1'b0;
      set_store(5'b00010, 32'h0000_0404, 32'h0BAD_0BAD);
      step();
      drain(4);
      reset = 1'b0;
      step();
      reset = 1'b1;
      step();

      // Random traffic with address reuse so loads alias and the queue fills
      for (int c = 0; c < 1500; c++) begin
         rou_valid    = ($urandom_range(0, 1) == 1);
         rou_store    = ($urandom_range(0, 3) != 0);
         rou_alu      = 5'($urandom);
         rou_sq_waddr = 32'h1000 + $urandom_range(0, 15);
         rou_sq_wdata = $urandom;
         rou_pc       = $urandom;
         mem_wready   = ($urandom_range(0, 2) != 0);
         mem_bvalid   = ($urandom_range(0, 2) != 0);
         mem_berr     = ($urandom_range(0, 15) == 0);
         ld_raddr     = 32'h1000 + $urandom_range(0, 19);
         reset        = ($urandom_range(0, 249) != 0);
         step();
      end
      reset = 1'b1;
      drain(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
